mdu_iterative: RTL and testbench

Iterative RV32M multiply/divide unit for the execute stage, the multi-cycle companion to the single-cycle ALU decode path. It accepts one M-extension operation (funct7 = 0000001) per start pulse and computes it with a shift-add multiplier or a restoring divider, one bit per cycle. It returns a registered result with a one-cycle done pulse. The hazard unit stalls the pipeline while busy is high.

---
 rtl/mdu_iterative_if.sv | 24 ++
 rtl/mdu_iterative.sv | 163 ++++++++++++++++
 tb/tb_mdu_iterative.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/mdu_iterative_if.sv
// rtl/mdu_iterative_if.sv - request/response bundle between the execute stage and the iterative MDU.
`timescale 1ns/1ps
interface mdu_iterative_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            flush;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (
        output start, funct3, rs1, rs2, flush,
        input  busy, done, result
    );

    modport slave (
        input  start, funct3, rs1, rs2, flush,
        output busy, done, result
    );
endinterface

// File: rtl/mdu_iterative.sv
// rtl/mdu_iterative.sv - iterative RV32M multiply/divide unit, one bit per cycle.
// Optional MDU_FAST_MUL_EN: multiplies complete in the accept cycle via a combinational multiplier.
`timescale 1ns/1ps
module mdu_iterative #(
    parameter int XLEN = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    mdu_iterative_if.slave bus
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_e;

    state_e            state_q, state_d;
    logic [2:0]        op_q, op_d;
    logic [XLEN-1:0]   mag_a_q, mag_a_d;
    logic [XLEN-1:0]   mag_b_q, mag_b_d;
    logic              neg_q, neg_d;
    logic [2*XLEN-1:0] prod_q, prod_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [XLEN-1:0]   result_q, result_d;

    // Operand decode, evaluated on the request inputs in the accept cycle
    logic            a_signed, b_signed, a_neg, b_neg, is_div;
    logic            div_zero, div_ovf, acc_neg;
    logic [XLEN-1:0] acc_mag_a, acc_mag_b, special_res;

    always_comb begin
        a_signed  = (bus.funct3 != 3'b011) && (bus.funct3 != 3'b101) && (bus.funct3 != 3'b111);
        b_signed  = a_signed && (bus.funct3 != 3'b010);
        a_neg     = a_signed && bus.rs1[XLEN-1];
        b_neg     = b_signed && bus.rs2[XLEN-1];
        acc_mag_a = a_neg ? -bus.rs1 : bus.rs1;
        acc_mag_b = b_neg ? -bus.rs2 : bus.rs2;
        is_div    = bus.funct3[2];
        // Remainder follows the dividend; everything else follows the sign product
        acc_neg   = (is_div && bus.funct3[1]) ? a_neg : (a_neg ^ b_neg);
        div_zero  = is_div && (bus.rs2 == '0);
        div_ovf   = is_div && !bus.funct3[0] && (bus.rs1 == MIN_NEG) && (bus.rs2 == '1);
        if (div_zero) begin
            special_res = bus.funct3[1] ? bus.rs1 : '1;
        end else begin
            special_res = bus.funct3[1] ? '0 : bus.rs1;
        end
    end

`ifdef MDU_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_a, fast_b, fast_p;
    logic [XLEN-1:0]   fast_res;

    always_comb begin
        fast_a   = {{XLEN{a_signed && bus.rs1[XLEN-1]}}, bus.rs1};
        fast_b   = {{XLEN{b_signed && bus.rs2[XLEN-1]}}, bus.rs2};
        fast_p   = fast_a * fast_b;
        fast_res = (bus.funct3 == 3'b000) ? fast_p[XLEN-1:0] : fast_p[2*XLEN-1:XLEN];
    end
`endif

    // One iteration: prod_q holds {acc, multiplier} for multiply, {rem, quotient} for divide
    logic [XLEN:0]     mul_sum, div_shift, div_diff;
    logic [2*XLEN-1:0] mul_next, div_next, step_next, prod_sgn;
    logic [XLEN-1:0]   lo_sgn, hi_sgn, final_res;

    always_comb begin
        mul_sum   = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mag_a_q} : '0);
        mul_next  = {mul_sum, prod_q[XLEN-1:1]};
        div_shift = {prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]};
        div_diff  = div_shift - {1'b0, mag_b_q};
        if (div_diff[XLEN]) begin
            div_next = {div_shift[XLEN-1:0], prod_q[XLEN-2:0], 1'b0};
        end else begin
            div_next = {div_diff[XLEN-1:0], prod_q[XLEN-2:0], 1'b1};
        end
        step_next = op_q[2] ? div_next : mul_next;
        prod_sgn  = neg_q ? -step_next : step_next;
        lo_sgn    = neg_q ? -step_next[XLEN-1:0] : step_next[XLEN-1:0];
        hi_sgn    = neg_q ? -step_next[2*XLEN-1:XLEN] : step_next[2*XLEN-1:XLEN];
        if (op_q[2]) begin
            final_res = op_q[1] ? hi_sgn : lo_sgn;
        end else begin
            final_res = (op_q == 3'b000) ? prod_sgn[XLEN-1:0] : prod_sgn[2*XLEN-1:XLEN];
        end
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        mag_a_d  = mag_a_q;
        mag_b_d  = mag_b_q;
        neg_d    = neg_q;
        prod_d   = prod_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start && !bus.flush) begin
                    op_d    = bus.funct3;
                    mag_a_d = acc_mag_a;
                    mag_b_d = acc_mag_b;
                    neg_d   = acc_neg;
                    cnt_d   = '0;
                    prod_d  = is_div ? {{XLEN{1'b0}}, acc_mag_a} : {{XLEN{1'b0}}, acc_mag_b};
                    if (div_zero || div_ovf) begin
                        result_d = special_res;
                        state_d  = S_DONE;
                    end
`ifdef MDU_FAST_MUL_EN
                    else if (!is_div) begin
                        result_d = fast_res;
                        state_d  = S_DONE;
                    end
`endif
                    else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                prod_d = step_next;
                cnt_d  = cnt_q + CW'(1);
                if (cnt_q == CW'(XLEN - 1)) begin
                    result_d = final_res;
                    state_d  = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // An aborted operation must leave the previous result visible
        if (bus.flush) begin
            state_d  = S_IDLE;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            mag_a_q  <= '0;
            mag_b_q  <= '0;
            neg_q    <= 1'b0;
            prod_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            mag_a_q  <= mag_a_d;
            mag_b_q  <= mag_b_d;
            neg_q    <= neg_d;
            prod_q   <= prod_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign bus.busy   = (state_q != S_IDLE);
    assign bus.done   = (state_q == S_DONE);
    assign bus.result = result_q;
endmodule

// File: tb/tb_mdu_iterative.sv
// tb/tb_mdu_iterative.sv - directed self-checking bench for mdu_iterative.
`timescale 1ns/1ps
module tb_mdu_iterative;
    localparam int XLEN = 32;
`ifdef MDU_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] last_res;

    mdu_iterative_if #(.XLEN(XLEN)) bus ();

    mdu_iterative #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives the request there (cycle 0) and follows it to completion.
    task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat,
                          input bit poke);
        int n;
        bus.start  = 1'b1;
        bus.funct3 = f3;
        bus.rs1    = a;
        bus.rs2    = b;
        @(negedge clk);
        n = 1;
        bus.start = 1'b0;
        while (bus.done !== 1'b1 && n < 80) begin
            bus.rs1    = $urandom;
            bus.rs2    = $urandom;
            bus.funct3 = 3'($urandom_range(0, 7));
            bus.start  = poke && (n == 3);
            @(negedge clk);
            n++;
        end
        bus.start = 1'b0;
        check({tag, "_done_cycle"}, 32'(n), 32'(lat));
        check({tag, "_result"}, bus.result, exp);
        check({tag, "_busy_in_done"}, 32'(bus.busy), 32'd1);
        last_res = exp;
        @(negedge clk);
        check({tag, "_busy_after"}, 32'(bus.busy), 32'd0);
        check({tag, "_done_after"}, 32'(bus.done), 32'd0);
        check({tag, "_result_hold"}, bus.result, exp);
    endtask

    initial begin
        int saw_done;
        rst_n      = 1'b0;
        bus.start  = 1'b0;
        bus.flush  = 1'b0;
        bus.funct3 = 3'b000;
        bus.rs1    = '0;
        bus.rs2    = '0;
        #12;
        check("reset_busy", 32'(bus.busy), 32'd0);
        check("reset_done", 32'(bus.done), 32'd0);
        check("reset_result", bus.result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, MUL_LAT, 1'b0);
        run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, MUL_LAT, 1'b0);
        run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_LAT, 1'b0);
        run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, MUL_LAT, 1'b0);
        run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33, 1'b0);
        run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33, 1'b0);
        run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       33, 1'b0);
        run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        33, 1'b1);
        run_op("divu_z", 3'b101, 32'h1234,     32'h0,        32'hFFFFFFFF, 1, 1'b0);
        run_op("rem_z",  3'b110, 32'h1234,     32'h0,        32'h1234,     1, 1'b0);
        run_op("rem_ov", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h0,        1, 1'b0);
        run_op("div_ov", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0);

        // Flush in cycle 10 of a DIVU
        bus.start  = 1'b1;
        bus.funct3 = 3'b101;
        bus.rs1    = 32'd100;
        bus.rs2    = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        saw_done  = 0;
        repeat (9) begin
            if (bus.done === 1'b1) saw_done = 1;
            @(negedge clk);
        end
        bus.flush = 1'b1;
        @(negedge clk);
        bus.flush = 1'b0;
        check("flush_saw_done", 32'(saw_done), 32'd0);
        check("flush_busy", 32'(bus.busy), 32'd0);
        check("flush_done", 32'(bus.done), 32'd0);
        check("flush_result", bus.result, last_res);
        run_op("after_flush", 3'b101, 32'h1000, 32'h10, 32'h100, 33, 1'b0);

        // Flush and start together: request is dropped
        bus.flush  = 1'b1;
        bus.start  = 1'b1;
        bus.funct3 = 3'b101;
        bus.rs1    = 32'h1234;
        bus.rs2    = 32'h0;
        @(negedge clk);
        bus.flush = 1'b0;
        bus.start = 1'b0;
        check("flush_start_busy", 32'(bus.busy), 32'd0);
        @(negedge clk);
        check("flush_start_done", 32'(bus.done), 32'd0);
        check("flush_start_result", bus.result, 32'h100);

        // Asynchronous reset in cycle 5 of a MUL
        bus.start  = 1'b1;
        bus.funct3 = 3'b000;
        bus.rs1    = 32'd7;
        bus.rs2    = 32'hFFFFFFFD;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(bus.busy), 32'd0);
        check("arst_done", 32'(bus.done), 32'd0);
        check("arst_result", bus.result, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op("post_rst", 3'b101, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 33, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
